gray_updown_counter: RTL and testbench

Parametrised up/down counter that holds its state in binary and presents the count as both binary and Gray code on registered outputs. It accepts a parallel load value in Gray code and converts it to binary internally with a DATA_SIZE-wide XOR-prefix. It is the sequential, width-generic successor to the fixed 4-bit Gray-to-binary converter. Typical uses are as a Gray pointer source for clock-domain-crossing logic and as a position counter for Gray-coded encoders.

---
 rtl/gray_updown_counter_if.sv | 41 ++++
 rtl/gray_updown_counter.sv | 70 +++++++
 tb/tb_gray_updown_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_updown_counter_if.sv
// Signal bundle for gray_updown_counter.
//
// Control strobes (en, up_dn, load, load_gray) are level-sampled on every
// rising clock edge; there is no valid/ready handshake. The counter is always
// ready, and a strobe high at an edge is consumed at that edge. The results
// (b_out, g_out, wrap) are registered and valid from the first reset onward.
interface gray_updown_counter_if #(
   parameter int DATA_SIZE = 4
);

   logic                 en;
   logic                 up_dn;
   logic                 load;
   logic [DATA_SIZE-1:0] load_gray;
   logic [DATA_SIZE-1:0] b_out;
   logic [DATA_SIZE-1:0] g_out;
   logic                 wrap;

   // Driver side: whoever controls the counter.
   modport master (
      output en,
      output up_dn,
      output load,
      output load_gray,
      input  b_out,
      input  g_out,
      input  wrap
   );

   // Counter side.
   modport slave (
      input  en,
      input  up_dn,
      input  load,
      input  load_gray,
      output b_out,
      output g_out,
      output wrap
   );

endinterface

// File: rtl/gray_updown_counter.sv
// Up/down counter holding its state in binary and presenting it as both binary
// and Gray code on registered outputs. A parallel load takes a Gray-coded value
// and converts it to binary with an XOR prefix from the MSB down.
// Edge priority: rst > load > en > hold.
module gray_updown_counter #(
   parameter int DATA_SIZE = 4,
   parameter int RESET_VAL = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   gray_updown_counter_if.slave  bus
);

   localparam logic [DATA_SIZE-1:0] RST_BIN  = DATA_SIZE'(RESET_VAL);
   localparam logic [DATA_SIZE-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
   localparam logic [DATA_SIZE-1:0] ONE      = {{(DATA_SIZE-1){1'b0}}, 1'b1};
   localparam logic [DATA_SIZE-1:0] ALL_ONES = {DATA_SIZE{1'b1}};

   logic [DATA_SIZE-1:0] bin_q;
   logic [DATA_SIZE-1:0] gray_q;
   logic                 wrap_q;

   logic [DATA_SIZE-1:0] bin_nxt;
   logic                 wrap_nxt;

   // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
   function automatic logic [DATA_SIZE-1:0] gray2bin(input logic [DATA_SIZE-1:0] g);
      logic [DATA_SIZE-1:0] b;
      b[DATA_SIZE-1] = g[DATA_SIZE-1];
      for (int i = DATA_SIZE - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Next binary value and wrap flag; a load never reports a wrap.
   always_comb begin
      bin_nxt  = bin_q;
      wrap_nxt = 1'b0;
      if (bus.load) begin
         bin_nxt = gray2bin(bus.load_gray);
      end else if (bus.en) begin
         if (bus.up_dn) begin
            bin_nxt  = bin_q + ONE;
            wrap_nxt = (bin_q == ALL_ONES);
         end else begin
            bin_nxt  = bin_q - ONE;
            wrap_nxt = (bin_q == '0);
         end
      end
   end

   // Binary and Gray are registered together from the same next value so they never skew.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= RST_BIN;
         gray_q <= RST_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_nxt;
         gray_q <= bin_nxt ^ (bin_nxt >> 1);
         wrap_q <= wrap_nxt;
      end
   end

   assign bus.b_out = bin_q;
   assign bus.g_out = gray_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a 4-bit instance (RESET_VAL=5) driven from a
// vector table and hand sequences, and an 8-bit instance driven randomly.
// Expected results are queued when stimulus is driven and compared after the edge.
module tb_gray_updown_counter;

   localparam int RV4 = 5;
   localparam int RV8 = 165;

   logic clk;
   logic rst4;
   logic rst8;

   gray_updown_counter_if #(.DATA_SIZE(4)) if4 ();
   gray_updown_counter_if #(.DATA_SIZE(8)) if8 ();

   gray_updown_counter #(.DATA_SIZE(4), .RESET_VAL(RV4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (if4.slave)
   );

   gray_updown_counter #(.DATA_SIZE(8), .RESET_VAL(RV8)) dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (if8.slave)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   logic [8:0]  exp4_q[$];
   logic [16:0] exp8_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int m4_b = 0;
   int m8_b = 0;

   typedef struct {
      bit         r;
      bit         ld;
      bit         e;
      bit         u;
      logic [3:0] lg;
      logic [3:0] b;
      logic [3:0] g;
      bit         w;
   } vec_t;

   vec_t tab[16];

   // Reference model: Gray-to-binary by searching for the value whose Gray code matches.
   function automatic int ref_g2b(input int n, input int g);
      int mask = (1 << n) - 1;
      for (int v = 0; v <= mask; v++) begin
         if (((v ^ (v >> 1)) & mask) == g) return v;
      end
      return -1;
   endfunction

   function automatic void model_step(input int n, input int cur, input bit r, input bit ld,
                                      input bit e, input bit u, input int lg, input int rv,
                                      output int nb, output bit nw);
      int mask = (1 << n) - 1;
      nb = cur;
      nw = 1'b0;
      if (r) begin
         nb = rv;
      end else if (ld) begin
         nb = ref_g2b(n, lg);
      end else if (e) begin
         if (u) begin
            nb = (cur + 1) & mask;
            nw = (cur == mask);
         end else begin
            nb = (cur - 1) & mask;
            nw = (cur == 0);
         end
      end
   endfunction

   task automatic check4(input string name);
      logic [8:0] exp;
      logic [8:0] act;
      act = {if4.b_out, if4.g_out, if4.wrap};
      n_checks++;
      if (exp4_q.size() == 0) begin
         $display("FAIL %s: no expected entry queued, got b=%h g=%h w=%b", name, act[8:5], act[4:1], act[0]);
         return;
      end
      exp = exp4_q.pop_front();
      if (act === exp) n_pass++;
      else $display("FAIL %s: got b=%h g=%h w=%b, want b=%h g=%h w=%b",
                    name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
   endtask

   task automatic check8(input string name);
      logic [16:0] exp;
      logic [16:0] act;
      act = {if8.b_out, if8.g_out, if8.wrap};
      n_checks++;
      if (exp8_q.size() == 0) begin
         $display("FAIL %s: no expected entry queued, got b=%h g=%h w=%b", name, act[16:9], act[8:1], act[0]);
         return;
      end
      exp = exp8_q.pop_front();
      if (act === exp) n_pass++;
      else $display("FAIL %s: got b=%h g=%h w=%b, want b=%h g=%h w=%b",
                    name, act[16:9], act[8:1], act[0], exp[16:9], exp[8:1], exp[0]);
   endtask

   task automatic check_cond(input string name, input bit ok, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, req);
   endtask

   // Driver for the 4-bit instance; use_tab selects a table expectation over the model.
   task automatic drive4(input bit r, input bit ld, input bit e, input bit u, input logic [3:0] lg,
                         input bit use_tab, input logic [8:0] tab_exp, input string name);
      int nb;
      bit nw;
      @(negedge clk);
      rst4          = r;
      if4.load      = ld;
      if4.en        = e;
      if4.up_dn     = u;
      if4.load_gray = lg;
      model_step(4, m4_b, r, ld, e, u, int'(lg), RV4, nb, nw);
      m4_b = nb;
      if (use_tab) exp4_q.push_back(tab_exp);
      else exp4_q.push_back({4'(nb), 4'(nb ^ (nb >> 1)), nw});
      @(posedge clk);
      #1;
      check4(name);
   endtask

   task automatic drive8(input bit r, input bit ld, input bit e, input bit u, input logic [7:0] lg,
                         input string name);
      int nb;
      bit nw;
      @(negedge clk);
      rst8          = r;
      if8.load      = ld;
      if8.en        = e;
      if8.up_dn     = u;
      if8.load_gray = lg;
      model_step(8, m8_b, r, ld, e, u, int'(lg), RV8, nb, nw);
      m8_b = nb;
      exp8_q.push_back({8'(nb), 8'(nb ^ (nb >> 1)), nw});
      @(posedge clk);
      #1;
      check8(name);
   endtask

   // Stimulus and checking
   initial begin
      logic [3:0] prev_g;
      int         wraps;
      bit         r, ld, e, u;

      rst4 = 1'b1;
      rst8 = 1'b1;
      if4.en = 1'b0; if4.up_dn = 1'b0; if4.load = 1'b0; if4.load_gray = '0;
      if8.en = 1'b0; if8.up_dn = 1'b0; if8.load = 1'b0; if8.load_gray = '0;

      //            r  ld e  u  lg     b      g      w
      tab[0]  = '{1, 0, 0, 0, 4'h0, 4'h5, 4'h7, 0};  // reset to 5
      tab[1]  = '{0, 0, 0, 0, 4'h0, 4'h5, 4'h7, 0};  // hold
      tab[2]  = '{0, 0, 0, 1, 4'h0, 4'h5, 4'h7, 0};  // hold
      tab[3]  = '{0, 0, 0, 0, 4'h0, 4'h5, 4'h7, 0};  // hold
      tab[4]  = '{0, 1, 0, 0, 4'hD, 4'h9, 4'hD, 0};  // load 1101 -> 9
      tab[5]  = '{0, 1, 0, 0, 4'h8, 4'hF, 4'h8, 0};  // load 15
      tab[6]  = '{0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 1};  // up wrap
      tab[7]  = '{0, 0, 1, 1, 4'h0, 4'h1, 4'h1, 0};  // up
      tab[8]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0};  // down to 0
      tab[9]  = '{0, 0, 1, 0, 4'h0, 4'hF, 4'h8, 1};  // down wrap
      tab[10] = '{0, 0, 0, 0, 4'h0, 4'hF, 4'h8, 0};  // hold clears wrap
      tab[11] = '{0, 1, 0, 0, 4'h4, 4'h7, 4'h4, 0};  // load 7
      tab[12] = '{0, 1, 1, 1, 4'h3, 4'h2, 4'h3, 0};  // load beats en
      tab[13] = '{1, 1, 1, 1, 4'hF, 4'h5, 4'h7, 0};  // rst beats load
      tab[14] = '{0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0};  // load 0, no wrap
      tab[15] = '{0, 1, 1, 0, 4'h8, 4'hF, 4'h8, 0};  // load all-ones, no wrap

      drive8(1, 0, 0, 0, 8'h00, "rst8");

      for (int i = 0; i < 16; i++) begin
         drive4(tab[i].r, tab[i].ld, tab[i].e, tab[i].u, tab[i].lg, 1'b1,
                {tab[i].b, tab[i].g, tab[i].w}, $sformatf("tab%0d", i));
      end

      // Every Gray code loaded in turn.
      for (int i = 0; i < 16; i++) begin
         drive4(0, 1, 0, 0, 4'(i), 1'b0, 9'h0, $sformatf("load_g%0d", i));
      end

      // From 0: one step down wraps, then 16 more steps give exactly one more wrap.
      drive4(0, 1, 0, 0, 4'h0, 1'b0, 9'h0, "load0");
      drive4(0, 0, 1, 0, 4'h0, 1'b0, 9'h0, "down_wrap");
      wraps  = 0;
      prev_g = if4.g_out;
      for (int i = 0; i < 16; i++) begin
         drive4(0, 0, 1, 0, 4'h0, 1'b0, 9'h0, $sformatf("down%0d", i));
         check_cond($sformatf("gray_step%0d", i), $countones(if4.g_out ^ prev_g) == 1,
                    $countones(if4.g_out ^ prev_g), 1);
         prev_g = if4.g_out;
         if (if4.wrap) wraps++;
      end
      check_cond("down_wrap_count", wraps == 1, wraps, 1);

      // Mid-count reset.
      drive4(0, 0, 1, 1, 4'h0, 1'b0, 9'h0, "up_before_rst");
      drive4(1, 0, 1, 1, 4'h0, 1'b0, 9'h0, "rst_mid_count");
      drive4(0, 0, 0, 0, 4'h0, 1'b0, 9'h0, "hold_after_rst");

      // 8-bit: direction toggles at 255 and at 0.
      drive8(0, 1, 0, 0, 8'h80, "load255");
      drive8(0, 0, 1, 1, 8'h00, "up255");
      drive8(0, 0, 1, 0, 8'h00, "dn0");
      drive8(0, 0, 1, 0, 8'h00, "dn255");
      drive8(0, 0, 1, 1, 8'h00, "up254");
      drive8(0, 0, 1, 1, 8'h00, "up255b");
      drive8(0, 0, 1, 0, 8'h00, "dn0b");

      // 8-bit random run.
      for (int i = 0; i < 10000; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 9) == 0);
         e  = ($urandom_range(0, 9) < 7);
         u  = $urandom_range(0, 1);
         drive8(r, ld, e, u, 8'($urandom_range(0, 255)), "rand8");
      end

      check_cond("queue4_empty", exp4_q.size() == 0, exp4_q.size(), 0);
      check_cond("queue8_empty", exp8_q.size() == 0, exp8_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
